// File: rtl/frame_stream_source.sv
// Framed sample source: FIFO-buffered producer bytes streamed out as gap-free
// frames of FRAME_LEN samples, with an optional forced idle gap between frames.
module frame_stream_source #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned GAP_CYC   = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              EN,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic [DATA_W-1:0] output_data,
  output logic              data_start,
  output logic              data_valid,
  output logic              frame_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned LVL_W = ADDR_W + 1;
  localparam int unsigned IDX_W = $clog2(FRAME_LEN);
  localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_n;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level_n;
  logic [DATA_W-1:0] mem [DEPTH];

  logic push_c, pop_c, launch_ok_c, take_launch_c;
  logic start_n, valid_n, done_n;

  assign push_c      = wr_en && !full;
  assign launch_ok_c = EN && (level >= LVL_W'(FRAME_LEN));

  // Next-state and next-output decode; a launch is shared by IDLE, the last
  // STREAM cycle (no gap) and the last GAP cycle so gaps are exactly GAP_CYC.
  always_comb begin
    state_n       = state;
    idx_n         = idx;
    gap_cnt_n     = gap_cnt;
    pop_c         = 1'b0;
    start_n       = 1'b0;
    valid_n       = 1'b0;
    done_n        = 1'b0;
    take_launch_c = 1'b0;
    unique case (state)
      IDLE: begin
        take_launch_c = launch_ok_c;
      end
      STREAM: begin
        if (idx != IDX_W'(FRAME_LEN - 1)) begin
          pop_c   = 1'b1;
          valid_n = 1'b1;
          idx_n   = idx + IDX_W'(1);
          done_n  = (idx_n == IDX_W'(FRAME_LEN - 1));
        end else if (GAP_CYC != 0) begin
          state_n   = GAP;
          gap_cnt_n = '0;
        end else if (launch_ok_c) begin
          take_launch_c = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt != GAP_W'(GAP_CYC - 1)) begin
          gap_cnt_n = gap_cnt + GAP_W'(1);
        end else if (launch_ok_c) begin
          take_launch_c = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (take_launch_c) begin
      state_n = STREAM;
      idx_n   = '0;
      pop_c   = 1'b1;
      start_n = 1'b1;
      valid_n = 1'b1;
    end
  end

  always_comb begin
    level_n = level + LVL_W'(push_c) - LVL_W'(pop_c);
  end

  // State, FIFO bookkeeping and registered stream outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      idx         <= '0;
      gap_cnt     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      full        <= 1'b0;
      overflow    <= 1'b0;
      output_data <= '0;
      data_start  <= 1'b0;
      data_valid  <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      gap_cnt    <= gap_cnt_n;
      level      <= level_n;
      full       <= (level_n == LVL_W'(DEPTH));
      data_start <= start_n;
      data_valid <= valid_n;
      frame_done <= done_n;
      if (wr_en && full) overflow <= 1'b1;
      if (push_c) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_c) begin
        rd_ptr      <= rd_ptr + ADDR_W'(1);
        output_data <= mem[rd_ptr];
      end else begin
        output_data <= '0;
      end
    end
  end

  // Storage array carries no reset; pointers and level define its contents
  always_ff @(posedge CLK) begin
    if (push_c) mem[wr_ptr] <= wr_data;
  end

endmodule
